// File: rtl/mac_sequencer.sv
// mac_sequencer: clears a signed-weight MAC, streams vec_len operand pairs into it, pulses vec_done when the sum is final.
// Optional build macro MAC_SEQ_ZERO_SKIP_EN: accepted pairs with a zero operand count but do not enable the MAC.
module mac_sequencer #(
    parameter int MAX_LEN = 128,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [9:0]       in_b,
    output logic [7:0]       mac_a,
    output logic [9:0]       mac_b,
    output logic             mac_en,
    output logic             mac_clr,
    output logic             busy,
    output logic             vec_done
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] len, len_n;
    logic [LEN_W-1:0] count, count_n;
    logic [7:0]       mac_a_n;
    logic [9:0]       mac_b_n;
    logic             mac_en_n;
    logic             mac_clr_n;
    logic             vec_done_n;
    logic             accept;
    logic             last;
    logic             skip;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req);
        return (req > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req;
    endfunction

    assign in_ready = (state == RUN);
    assign busy     = (state != IDLE);
    assign accept   = in_valid & in_ready;
    assign last     = (count == (len - LEN_W'(1)));

`ifdef MAC_SEQ_ZERO_SKIP_EN
    // A zero operand contributes nothing to the sum, so the MAC is left idle.
    assign skip = (in_a == 8'd0) || (in_b == 10'd0);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        len_n      = len;
        count_n    = count;
        mac_a_n    = mac_a;
        mac_b_n    = mac_b;
        mac_en_n   = 1'b0;
        mac_clr_n  = 1'b0;
        vec_done_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n   = CLEAR;
                    len_n     = clamp_len(vec_len);
                    count_n   = '0;
                    mac_clr_n = 1'b1;
                end
            end
            CLEAR: begin
                state_n = (len == '0) ? DRAIN : RUN;
            end
            RUN: begin
                if (accept) begin
                    count_n = count + LEN_W'(1);
                    if (!skip) begin
                        mac_a_n  = in_a;
                        mac_b_n  = in_b;
                        mac_en_n = 1'b1;
                    end
                    if (last) state_n = DRAIN;
                end
            end
            DRAIN: begin
                // The last accumulate edge is the one leaving DRAIN, so done lands right after it.
                vec_done_n = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            len      <= '0;
            count    <= '0;
            mac_a    <= '0;
            mac_b    <= '0;
            mac_en   <= 1'b0;
            mac_clr  <= 1'b1;
            vec_done <= 1'b0;
        end else begin
            state    <= state_n;
            len      <= len_n;
            count    <= count_n;
            mac_a    <= mac_a_n;
            mac_b    <= mac_b_n;
            mac_en   <= mac_en_n;
            mac_clr  <= mac_clr_n;
            vec_done <= vec_done_n;
        end
    end

endmodule
